// File: rtl/pd_pkg.sv
// Shared types and defaults for the path delay scheduler.
package pd_pkg;

    localparam int PD_DW = 8;

    typedef enum logic [1:0] {
        PD_IDLE  = 2'd0,
        PD_PEND  = 2'd1,
        PD_XHOLD = 2'd2
    } pd_state_e;

endpackage

// File: rtl/pd_delay_counter.sv
// Loadable down-counter that stops at zero; flags the last cycle (==1)
// and the drained state (==0).
module pd_delay_counter #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    input  logic          dec,
    output logic          is_one,
    output logic          is_zero
);

    logic [DW-1:0] cnt;

    // Load takes priority; decrement never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign is_one  = (cnt == DW'(1));
    assign is_zero = (cnt == '0);

endmodule

// File: rtl/path_delay_scheduler.sv
// Single-bit path delay scheduler: rise/fall delays, pulse rejection and
// cancelled-pulse reporting (on-event / on-detect) with an X window.
module path_delay_scheduler
    import pd_pkg::*;
#(
    parameter int DW = PD_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] cfg_rise,
    input  logic [DW-1:0] cfg_fall,
    input  logic [DW-1:0] cfg_reject,
    input  logic          cfg_ondetect,
    input  logic          cfg_showcancel,
    input  logic          din,
    output logic          dout,
    output logic          dout_x,
    output logic          cancel_pulse,
    output logic          busy
);

    pd_state_e     state, state_nx;
    logic          tgt, tgt_nx;
    logic          dout_nx, dout_x_nx, cancel_nx;
    logic [DW-1:0] age, age_nx;
    logic [DW-1:0] d_raw, d_eff;
    logic          cnt_load, cnt_dec, cnt_one, cnt_zero;

    // Delay for a new event: direction picks rise/fall, zero means one cycle.
    always_comb begin
        d_raw = din ? cfg_rise : cfg_fall;
        d_eff = (d_raw == '0) ? DW'(1) : d_raw;
    end

    // The same counter times the pending event and, after a shown cancel,
    // keeps running so the X window lines up with the would-be maturity.
    pd_delay_counter #(.DW(DW)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (d_eff),
        .dec      (cnt_dec),
        .is_one   (cnt_one),
        .is_zero  (cnt_zero)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_nx  = state;
        tgt_nx    = tgt;
        dout_nx   = dout;
        dout_x_nx = dout_x;
        cancel_nx = 1'b0;
        age_nx    = age;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        unique case (state)
            PD_IDLE: begin
                if (din != tgt) begin
                    cnt_load = 1'b1;
                    age_nx   = DW'(1);
                    tgt_nx   = din;
                    state_nx = PD_PEND;
                end
            end
            PD_PEND: begin
                if (din == tgt) begin
                    cnt_dec = 1'b1;
                    age_nx  = (age == '1) ? age : age + 1'b1;
                    if (cnt_one) begin
                        dout_nx  = tgt;
                        state_nx = PD_IDLE;
                    end
                end else begin
                    // Reversion: age holds the width of the aborted pulse.
                    tgt_nx = dout;
                    if (age < cfg_reject) begin
                        state_nx = PD_IDLE;
                    end else begin
                        cancel_nx = 1'b1;
                        if (cfg_showcancel) begin
                            cnt_dec  = 1'b1;
                            state_nx = PD_XHOLD;
                            if (cfg_ondetect) dout_x_nx = 1'b1;
                        end else begin
                            state_nx = PD_IDLE;
                        end
                    end
                end
            end
            PD_XHOLD: begin
                if (din != dout) begin
                    // New change cuts the X window short and is scheduled now.
                    dout_x_nx = 1'b0;
                    cnt_load  = 1'b1;
                    age_nx    = DW'(1);
                    tgt_nx    = din;
                    state_nx  = PD_PEND;
                end else if (cnt_one) begin
                    // Would-be maturity: X is shown here in either style.
                    dout_x_nx = 1'b1;
                    cnt_dec   = 1'b1;
                end else if (cnt_zero) begin
                    dout_x_nx = 1'b0;
                    state_nx  = PD_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_nx = PD_IDLE;
        endcase
    end

    // State, target, age and all outputs are registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= PD_IDLE;
            tgt          <= 1'b0;
            age          <= '0;
            dout         <= 1'b0;
            dout_x       <= 1'b0;
            cancel_pulse <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nx;
            tgt          <= tgt_nx;
            age          <= age_nx;
            dout         <= dout_nx;
            dout_x       <= dout_x_nx;
            cancel_pulse <= cancel_nx;
            busy         <= (state_nx != PD_IDLE);
        end
    end

endmodule

// File: doc/path_delay_scheduler.md
# path_delay_scheduler

- Single-bit module-path delay scheduler.
  - Applies programmable rise/fall delays, in clock cycles, to an input.
  - Filters pulses narrower than a reject limit.
  - Reports cancelled (unfiltered but too-short) pulses, with on-event or on-detect style.
- Hardware counterpart of specify-block path delays: sits between a functional output and its pin model.

## Interface
Parameters:
- DW, 8: width of the delay, reject and age counters.

Ports:
- clk, in, 1: clock; all state updates on rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- cfg_rise, in, DW: 0->1 delay in cycles; 0 treated as 1.
- cfg_fall, in, DW: 1->0 delay in cycles; 0 treated as 1.
- cfg_reject, in, DW: pulses of width < cfg_reject are silently filtered; 0 disables filtering.
- cfg_ondetect, in, 1: 1 = on-detect style, 0 = on-event style.
- cfg_showcancel, in, 1: 1 = drive dout_x on cancelled pulses.
- din, in, 1: functional input, synchronous to clk.
- dout, out, 1: delayed output.
- dout_x, out, 1: unknown-value indicator for a cancelled event.
- cancel_pulse, out, 1: one-cycle strobe per cancelled (non-rejected) pulse.
- busy, out, 1: high when state != IDLE.

## Operation
- State registers:
  - tgt: last scheduled value.
  - cnt: cycles to maturity.
  - age: width of the current pulse, saturating.
  - FSM: IDLE, PEND, XHOLD.
- Reset: dout=0, dout_x=0, cancel_pulse=0, busy=0, tgt=0, FSM=IDLE, all counters 0.
- IDLE (tgt==dout): at edge k with din!=tgt:
  - D = cfg_rise if din=1, else cfg_fall; D=0 is forced to 1.
  - Load cnt<=D, age<=1, tgt<=din; go to PEND.
  - cfg_rise/cfg_fall are sampled only at this edge.
- PEND, din==tgt: cnt decrements and age increments.
  - At the edge where cnt==1: dout<=tgt, go to IDLE. dout therefore changes at edge k+D.
- PEND, din!=tgt (reversion) at edge k+j, j<D: pulse width w=j; tgt<=dout.
  - w < cfg_reject: discard the event, go to IDLE. No strobe, no dout_x.
  - Otherwise: cancel_pulse=1 for one cycle, and the event is discarded.
    - cfg_showcancel=0: go to IDLE.
    - cfg_showcancel=1: keep cnt running (remaining D-j), go to XHOLD. Style bits are sampled at the reversion edge.
    - On-detect: dout_x<=1 at the reversion edge.
    - On-event: dout_x<=1 at the would-be maturity edge k+D.
    - Both styles: dout_x<=0 and go to IDLE at edge k+D+1. dout never changes.
- XHOLD, din!=dout at any edge: dout_x<=0 immediately, then schedule a new event exactly as from IDLE at that edge.
- Pulse width saturates at 2^DW-1. Comparisons are unsigned.
- Config changes while PEND do not affect the pending event.

## Timing
- Latency din->dout = D cycles; minimum 1. There is no combinational path from din to any output.
- Every output is registered, including busy.
- A reversion and maturity at the same edge cannot occur: maturity requires din==tgt at that edge.
- Asynchronous reset mid-operation: outputs return to reset values immediately and the pending event is lost.
  - After release, din=1 is scheduled afresh, as a 0->1 event against dout=0.
- Back-to-back events: a new change detected at the same edge dout matures is scheduled at the next edge (the FSM is in IDLE then).

## Structure
- Shared package pd_pkg: FSM state enum (PD_IDLE, PD_PEND, PD_XHOLD) and the default DW.
- One natural sub-module, pd_delay_counter: loadable saturating down-counter with an `==1` flag. Used for cnt and reused for the XHOLD window.
- age is a plain saturating incrementer inside the top module.

## Test plan
- Basic delays: rise=3, fall=5. din 0->1 sampled at edge 10 -> dout=1 at edge 13. din 1->0 at edge 20 -> dout=0 at edge 25. busy high edges 10-12 and 20-24.
- Filtered pulse: rise=6, reject=2. din high only at edge 10, reverting at 11 -> dout stays 0, cancel_pulse never asserts, busy low from edge 11.
- On-detect cancel: rise=6, reject=2, showcancel=1, ondetect=1. din high at edges 10-12, reverts at 13:
  - cancel_pulse high after edge 13.
  - dout_x high after edges 13-16, low at 17.
  - dout stays 0.
- On-event cancel: same stimulus with ondetect=0 -> dout_x high only after edge 16, low at 17.
- Zero delay: rise=fall=0 -> dout equals din delayed by exactly one cycle for a toggle every 2 cycles.
- Reset mid-PEND: rise=8, din 0->1 at edge 10, rst_n low between edges 12 and 13:
  - dout, busy and dout_x are 0 immediately.
  - Release before edge 15 with din=1 -> dout=1 at edge 23.
